// File: rtl/bk_add_io_stage.sv
// bk_add_io_stage
//   Sequential wrapper around the 12-bit combinational Brent-Kung adder.
//   An operand pair accepted over in_valid/in_ready is registered and driven
//   interleaved onto the adder input bus. The bus is held for SETTLE_CYC
//   cycles, then the adder result is pushed into a first-word-fall-through
//   FIFO that is drained over out_valid/out_ready.
//
//   Optional feature macro: BK_SELF_CHECK_EN
//     defined   -> each pushed result is compared with A+B taken from the
//                  operand register; a mismatch sets the sticky chk_err port.
//     undefined -> no comparator and no chk_err port; timing is identical.
//
// Ports
//   clk, rst   clock (rising edge), synchronous active-high reset
//   in_valid   operand pair valid        in_ready   stage accepts pair
//   in_a/in_b  operands (W bits)
//   add_bus_o  to adder INPUTS, [2i]=A[i], [2i+1]=B[i]  (registered)
//   add_res_i  from adder OUTS, [W-1:0]=sum, [W]=carry out
//   out_valid  FIFO head valid           out_ready  downstream takes head
//   out_sum    FIFO head result (W+1 bits)
//   chk_err    sticky self-check error (BK_SELF_CHECK_EN only)
//
// state  | meaning
// IDLE   | no operand held, ready for a new pair
// SETTLE | operands on the bus, waiting for the adder to settle
// COMMIT | result valid on add_res_i, waiting for FIFO space to push

module bk_add_io_stage #(
   parameter int W          = 12,
   parameter int SETTLE_CYC = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic [2*W-1:0] add_bus_o,
   input  logic [W:0]     add_res_i,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W:0]     out_sum
`ifdef BK_SELF_CHECK_EN
  ,output logic           chk_err
`endif
);

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    FULL_CNT = FIFO_DEPTH[AW:0];
   localparam logic [3:0]     CNT_LOAD = 4'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COMMIT} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [2*W-1:0]  op_bus_q, op_bus_d;
   logic [W:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     fifo_cnt;
   logic            fifo_full, pop, can_push, push, accept;

   assign fifo_full = (fifo_cnt == FULL_CNT);
   assign out_valid = (fifo_cnt != '0);
   assign out_sum   = fifo_mem[rd_ptr];
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign can_push  = !fifo_full | pop;
   assign accept    = in_valid & in_ready;
   assign add_bus_o = op_bus_q;

   always_comb begin
      op_bus_d = '0;
      for (int i = 0; i < W; i++) begin
         op_bus_d[2*i]   = in_a[i];
         op_bus_d[2*i+1] = in_b[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_ready = 1'b0;
      push     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_d == 4'd0) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            in_ready = can_push;
            if (can_push) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (rst) in_ready = 1'b0;
      // A new pair overrides the IDLE return, giving back-to-back operation.
      if (accept) begin
         cnt_d   = CNT_LOAD;
         state_d = (CNT_LOAD == 4'd0) ? ST_COMMIT : ST_SETTLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_bus_q <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) op_bus_q <= op_bus_d;
         if (push) begin
            fifo_mem[wr_ptr] <= add_res_i;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

`ifdef BK_SELF_CHECK_EN
   logic [W-1:0] op_a, op_b;
   logic [W:0]   ref_sum;

   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < W; i++) begin
         op_a[i] = op_bus_q[2*i];
         op_b[i] = op_bus_q[2*i+1];
      end
      ref_sum = {1'b0, op_a} + {1'b0, op_b};
   end

   always_ff @(posedge clk) begin
      if (rst)                                 chk_err <= 1'b0;
      else if (push && (add_res_i != ref_sum)) chk_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_bk_add_io_stage.sv
module tb_bk_add_io_stage;
   localparam int W = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // instance 1: SETTLE_CYC=1
   logic           rst1, in_valid1, in_ready1, out_valid1, out_ready1;
   logic [W-1:0]   in_a1, in_b1, ma1, mb1;
   logic [2*W-1:0] bus1;
   logic [W:0]     res1, sum1;
   logic           bad_en;
   logic [W:0]     bad_val;
`ifdef BK_SELF_CHECK_EN
   logic           chk_err1;
`endif

   // instance 3: SETTLE_CYC=3
   logic           rst3, in_valid3, in_ready3, out_valid3, out_ready3;
   logic [W-1:0]   in_a3, in_b3, ma3, mb3;
   logic [2*W-1:0] bus3;
   logic [W:0]     res3, sum3;
`ifdef BK_SELF_CHECK_EN
   logic           chk_err3;
`endif

   bk_add_io_stage #(.W(W), .SETTLE_CYC(1), .FIFO_DEPTH(2)) dut1 (
      .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .add_bus_o(bus1), .add_res_i(res1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(sum1)
`ifdef BK_SELF_CHECK_EN
     ,.chk_err(chk_err1)
`endif
   );

   bk_add_io_stage #(.W(W), .SETTLE_CYC(3), .FIFO_DEPTH(2)) dut3 (
      .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_a(in_a3), .in_b(in_b3), .add_bus_o(bus3), .add_res_i(res3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(sum3)
`ifdef BK_SELF_CHECK_EN
     ,.chk_err(chk_err3)
`endif
   );

   // Behavioural adder standing in for the Brent-Kung block.
   always_comb begin
      ma1 = '0; mb1 = '0; ma3 = '0; mb3 = '0;
      for (int i = 0; i < W; i++) begin
         ma1[i] = bus1[2*i]; mb1[i] = bus1[2*i+1];
         ma3[i] = bus3[2*i]; mb3[i] = bus3[2*i+1];
      end
      res1 = bad_en ? bad_val : ({1'b0, ma1} + {1'b0, mb1});
      res3 = {1'b0, ma3} + {1'b0, mb3};
   end

   function automatic logic [2*W-1:0] ilv(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         r[2*i]   = a[i];
         r[2*i+1] = b[i];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst1 = 1'b1; in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b0;
      rst3 = 1'b1; in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b0;
      bad_en = 1'b0; bad_val = '0;
      #1;
      check("rst_in_ready", 32'(in_ready1), 32'd0);
      tick(); tick();
      check("rst_bus", 32'(bus1), 32'd0);
      check("rst_out_valid", 32'(out_valid1), 32'd0);
      check("rst_out_sum", 32'(sum1), 32'd0);
`ifdef BK_SELF_CHECK_EN
      check("rst_chk_err", 32'(chk_err1), 32'd0);
`endif
      rst1 = 1'b0; rst3 = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready1), 32'd1);

      // 1: single op, latency
      out_ready1 = 1'b1; in_valid1 = 1'b1; in_a1 = 12'hFFF; in_b1 = 12'h001;
      tick();
      in_valid1 = 1'b0;
      check("t1_bus", 32'(bus1), 32'h555557);
      check("t1_valid_early", 32'(out_valid1), 32'd0);
      tick();
      check("t1_valid", 32'(out_valid1), 32'd1);
      check("t1_sum", 32'(sum1), 32'h1000);
      tick();
      check("t1_popped", 32'(out_valid1), 32'd0);

      // 2: back-to-back stream
      for (int i = 1; i <= 4; i++) begin
         in_valid1 = 1'b1; in_a1 = 12'(i); in_b1 = 12'(2*i);
         #1;
         check("t2_in_ready", 32'(in_ready1), 32'd1);
         tick();
         if (i >= 2) begin
            check("t2_valid", 32'(out_valid1), 32'd1);
            check("t2_sum", 32'(sum1), 32'(3*(i-1)));
         end
      end
      in_valid1 = 1'b0;
      tick();
      check("t2_sum4", 32'(sum1), 32'h00C);
      tick();
      check("t2_empty", 32'(out_valid1), 32'd0);

      // 3: full backpressure, capacity FIFO_DEPTH+1
      out_ready1 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         in_valid1 = 1'b1; in_a1 = 12'(16*k); in_b1 = 12'(k);
         #1;
         check("t3_accept", 32'(in_ready1), 32'd1);
         tick();
      end
      in_a1 = 12'h040; in_b1 = 12'h004;
      #1;
      check("t3_stall", 32'(in_ready1), 32'd0);
      tick(); tick();
      check("t3_stall2", 32'(in_ready1), 32'd0);
      check("t3_hold_bus", 32'(bus1), 32'(ilv(12'h030, 12'h003)));
      check("t3_head", 32'(sum1), 32'h011);
      out_ready1 = 1'b1;
      #1;
      check("t3_ready_on_pop", 32'(in_ready1), 32'd1);
      tick();
      in_valid1 = 1'b0;
      check("t3_bus4", 32'(bus1), 32'(ilv(12'h040, 12'h004)));
      check("t3_d2", 32'(sum1), 32'h022);
      tick();
      check("t3_d3", 32'(sum1), 32'h033);
      tick();
      check("t3_d4", 32'(sum1), 32'h044);
      check("t3_d4_valid", 32'(out_valid1), 32'd1);
      tick();
      check("t3_empty", 32'(out_valid1), 32'd0);

      // 4: SETTLE_CYC=3
      out_ready3 = 1'b1; in_valid3 = 1'b1; in_a3 = 12'h800; in_b3 = 12'h800;
      #1;
      check("t4_in_ready", 32'(in_ready3), 32'd1);
      tick();
      in_valid3 = 1'b0;
      check("t4_bus_a", 32'(bus3), 32'hC00000);
      check("t4_settle_rdy_a", 32'(in_ready3), 32'd0);
      check("t4_valid_a", 32'(out_valid3), 32'd0);
      tick();
      check("t4_bus_b", 32'(bus3), 32'hC00000);
      check("t4_settle_rdy_b", 32'(in_ready3), 32'd0);
      check("t4_valid_b", 32'(out_valid3), 32'd0);
      tick();
      check("t4_bus_c", 32'(bus3), 32'hC00000);
      check("t4_valid_c", 32'(out_valid3), 32'd0);
      tick();
      check("t4_valid", 32'(out_valid3), 32'd1);
      check("t4_sum", 32'(sum3), 32'h1000);
      tick();
      check("t4_popped", 32'(out_valid3), 32'd0);

      // 5: reset during SETTLE with two FIFO entries
      out_ready3 = 1'b0; in_valid3 = 1'b1; in_a3 = 12'h0AB; in_b3 = 12'h123;
      for (int n = 0; n < 7; n++) tick();
      in_valid3 = 1'b0;
      check("t5_settle_rdy", 32'(in_ready3), 32'd0);
      check("t5_valid", 32'(out_valid3), 32'd1);
      check("t5_head", 32'(sum3), 32'h1CE);
      rst3 = 1'b1;
      #1;
      check("t5_rst_rdy", 32'(in_ready3), 32'd0);
      tick();
      check("t5_valid_clr", 32'(out_valid3), 32'd0);
      check("t5_bus_clr", 32'(bus3), 32'd0);
      rst3 = 1'b0; out_ready3 = 1'b1;
      #1;
      check("t5_idle_rdy", 32'(in_ready3), 32'd1);
      for (int n = 0; n < 4; n++) begin
         tick();
         check("t5_no_stale", 32'(out_valid3), 32'd0);
      end

`ifdef BK_SELF_CHECK_EN
      // 6: sticky self-check error
      check("t6_clean", 32'(chk_err1), 32'd0);
      bad_en = 1'b1; bad_val = 13'h011;
      in_valid1 = 1'b1; in_a1 = 12'h00F; in_b1 = 12'h001;
      tick();
      in_valid1 = 1'b0;
      check("t6_pre_push", 32'(chk_err1), 32'd0);
      tick();
      bad_en = 1'b0;
      check("t6_err_set", 32'(chk_err1), 32'd1);
      in_valid1 = 1'b1; in_a1 = 12'h001; in_b1 = 12'h002;
      tick();
      in_valid1 = 1'b0;
      tick();
      check("t6_good_sum", 32'(sum1), 32'h003);
      check("t6_sticky", 32'(chk_err1), 32'd1);
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      check("t6_rst_clr", 32'(chk_err1), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
